// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, NOP encoding and entry bundle for pipeline stage registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int unsigned PIPE_PC_W   = 32;
  localparam int unsigned PIPE_DATA_W = 32;

  // Payload presented downstream when a stage holds nothing (all-zero bubble).
  localparam logic [PIPE_DATA_W-1:0] PIPE_NOP = '0;

  // One held entry at the default widths; stages built with other widths mirror this layout.
  typedef struct packed {
    logic [PIPE_PC_W-1:0]   pc;
    logic [PIPE_DATA_W-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: W-bit event counter that sticks at all-ones, cleared by reset.
// Latency: count reflects an increment one cycle after i_inc.
// Backpressure: none; counts every cycle i_inc is high.
// Only compiled into builds with PIPE_STAGE_PERF_EN, the sole user of this block.
`ifdef PIPE_STAGE_PERF_EN
module pipe_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Increment on each event until the counter reaches all-ones, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pipe_skid_stage_reg.sv
// pipe_skid_stage_reg: PC+payload pipeline register, valid/ready with a 2-entry skid buffer.
// Latency: 1 cycle from acceptance into an empty stage to out_*; 1 entry/cycle with out_ready=1.
// Backpressure: in_ready = ~skid_valid from a flop, no combinational ready path; flush wins.
// Optional: define PIPE_STAGE_PERF_EN to add saturating stall_cnt / flush_cnt outputs.
module pipe_skid_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       PC_W      = PIPE_PC_W,
  parameter int unsigned       DATA_W    = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(PIPE_NOP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // Same layout as pipe_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic   r_m_vld;
  logic   r_s_vld;
  entry_t r_m;
  entry_t r_s;

  logic   w_acc;
  logic   w_pop;
  entry_t w_in;

  assign w_in  = '{pc: in_pc, data: in_data};
  assign w_acc = in_valid & ~r_s_vld;
  assign w_pop = r_m_vld & out_ready;

  // Main/skid occupancy update; skid only fills when main is stalled, so order stays FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
      r_m     <= '0;
      r_s     <= '0;
    end else if (flush) begin
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else if (!r_m_vld) begin
      if (w_acc) begin
        r_m     <= w_in;
        r_m_vld <= 1'b1;
      end
    end else if (!r_s_vld) begin
      if (w_pop && w_acc) begin
        r_m <= w_in;
      end else if (w_pop) begin
        r_m_vld <= 1'b0;
      end else if (w_acc) begin
        r_s     <= w_in;
        r_s_vld <= 1'b1;
      end
    end else if (w_pop) begin
      r_m     <= r_s;
      r_s_vld <= 1'b0;
    end
  end

  assign in_ready  = ~r_s_vld;
  assign out_valid = r_m_vld;
  assign out_pc    = r_m_vld ? r_m.pc   : '0;
  assign out_data  = r_m_vld ? r_m.data : NOP_VALUE;

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = in_valid & ~r_s_vld ? 1'b0 : in_valid;
  assign w_flush_inc = flush & (r_m_vld | r_s_vld);

  pipe_sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  pipe_sat_counter #(.W(32)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_flush_inc),
    .o_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// tb_pipe_skid_stage_reg: directed stimulus with a FIFO scoreboard on the output handshake.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_skid_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;
  logic [31:0] hold_pc;

  always #5 clk = ~clk;

  pipe_skid_stage_reg u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample both handshakes mid-cycle, update the scoreboard, then advance one clock.
  task automatic tick();
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_out_qsize", 64'(sb_q.size()), 64'd1);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_out_entry", {out_pc, out_data}, sb_exp);
      end
    end
    if (flush) sb_q.delete();
    if (rst_n && !flush && in_valid && in_ready) sb_q.push_back({in_pc, in_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d);
    in_valid = v;
    in_pc    = pc;
    in_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    // Reset / idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_out_data", 64'(out_data), 64'd0);
    chk("idle_out_pc", 64'(out_pc), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      tick();
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_latency_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
    end
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    chk("stream_drained", 64'(sb_q.size()), 64'd0);

    // Skid fill and recovery
    drive(1'b1, 32'h200, 32'hB0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h204, 32'hB1);
    tick();
    chk("skid_in_ready_low", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h208, 32'hB2);
    hold_pc = out_pc;
    repeat (2) tick();
    chk("skid_hold_pc", 64'(out_pc), 64'(hold_pc));
    chk("skid_hold_pc_val", 64'(out_pc), 64'h200);
    chk("skid_hold_data", 64'(out_data), 64'hB0);
    chk("skid_in_ready_held", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("skid_in_ready_rise", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    chk("skid_no_loss", 64'(sb_q.size()), 64'd0);

    // Flush with both entries full
    out_ready = 1'b0;
    drive(1'b1, 32'h280, 32'hC0); tick();
    drive(1'b1, 32'h284, 32'hC1); tick();
    chk("flush_pre_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h300, 32'hC2);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_pc", 64'(out_pc), 64'd0);
    chk("flush_out_data", 64'(out_data), 64'd0);
    // Flush with main only: the entry accepted in the flush cycle is dropped
    drive(1'b1, 32'h308, 32'hC3); tick();
    flush = 1'b1;
    drive(1'b1, 32'h310, 32'hC4);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_acc_dropped", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flush_nothing_after", 64'(out_valid), 64'd0);

    // Async reset between edges while both entries are full
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'hD0); tick();
    drive(1'b1, 32'h404, 32'hD1); tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("arst_pre_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    sb_q.delete();
    #1 rst_n = 1'b1;
    tick();
    chk("arst_after_valid", 64'(out_valid), 64'd0);

`ifdef PIPE_STAGE_PERF_EN
    // Performance counters
    drive(1'b1, 32'h500, 32'hE0); tick();
    drive(1'b1, 32'h504, 32'hE1); tick();
    drive(1'b1, 32'h508, 32'hE2);
    repeat (5) tick();
    drive(1'b0, 32'h0, 32'h0);
    flush = 1'b1; tick();
    tick();
    flush = 1'b0;
    drive(1'b1, 32'h50C, 32'hE3); tick();
    drive(1'b0, 32'h0, 32'h0);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("perf_stall_cnt", 64'(stall_cnt), 64'd5);
    chk("perf_flush_cnt", 64'(flush_cnt), 64'd2);
    drive(1'b1, 32'h510, 32'hE4); tick();
    drive(1'b1, 32'h514, 32'hE5); tick();
    force u_dut.u_stall_cnt.r_cnt = 32'hFFFF_FFFE;
    #1;
    release u_dut.u_stall_cnt.r_cnt;
    drive(1'b1, 32'h518, 32'hE6);
    repeat (3) tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("perf_stall_sat", 64'(stall_cnt), 64'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
